// File: rtl/contador_crescente_sinc.sv
// Synchronous up counter built from JK toggle cells.
// Programmable modulus, parallel load (saturating), count enable,
// combinational terminal count and a sticky overflow flag.
// All cells share clk, so every bit changes on the same edge.

// One JK flip-flop with synchronous active-high reset.
// {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
module contador_crescente_sinc_jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK state update; rst forces 0 regardless of j/k
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

module contador_crescente_sinc #(
    parameter int WIDTH  = 5,
    parameter int MODULO = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // A modulus below 2 or above the representable range has no sensible
    // count sequence, so refuse to elaborate.
    if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
        $error("contador_crescente_sinc: MODULO out of range 2..2**WIDTH");
    end

    localparam int              MAX_COUNT = MODULO - 1;
    localparam logic [WIDTH-1:0] MAX_Q    = MAX_COUNT[WIDTH-1:0];
    // MODULO itself can equal 2**WIDTH, so it needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT  = MODULO[WIDTH:0];

    logic             at_max;
    logic             do_wrap;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;

    assign at_max   = (q == MAX_Q);
    // Wrap only happens on a counting edge; a load in the same cycle wins.
    assign do_wrap  = en & ~load & at_max;
    // Out-of-range load values saturate at the top of the sequence.
    assign load_val = ({1'b0, d} < MOD_EXT) ? d : MAX_Q;
    assign tc       = en & at_max;

    // carry[i] is high when all lower bits are 1, i.e. bit i must toggle
    // on a plain increment.
    assign carry[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign carry[i] = carry[i-1] & q[i-1];
    end

    // Per-bit J/K drive: load sets/clears each bit directly, wrap clears
    // every bit (needed for non power-of-two moduli), counting toggles.
    always_comb begin
        j_in = '0;
        k_in = '0;
        if (load) begin
            j_in = load_val;
            k_in = ~load_val;
        end else if (do_wrap) begin
            j_in = '0;
            k_in = '1;
        end else if (en) begin
            j_in = carry;
            k_in = carry;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        contador_crescente_sinc_jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_in[i]),
            .k   (k_in[i]),
            .q   (q[i])
        );
    end

    // Sticky overflow: a wrap sets it and beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (do_wrap) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_crescente_sinc.sv
// Bench for contador_crescente_sinc: a modulo-32 and a modulo-10 instance
// share one set of inputs and are checked every cycle against a plain
// arithmetic model, plus directed literal expectations.
module tb_contador_crescente_sinc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [4:0] d = '0;
    logic       clr_ovf = 1'b0;
    logic [4:0] q32, q10;
    logic       tc32, tc10, ovf32, ovf10;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    contador_crescente_sinc #(.WIDTH(5), .MODULO(32)) dut32 (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(q32), .tc(tc32), .ovf(ovf32)
    );

    contador_crescente_sinc #(.WIDTH(5), .MODULO(10)) dut10 (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(q10), .tc(tc10), .ovf(ovf10)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int  mq[2];
    bit  mo[2];
    int  mods[2] = '{32, 10};
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit wrap;
            wrap = !rst && !load && en && (mq[k] == mods[k] - 1);
            if (rst)       mq[k] = 0;
            else if (load) mq[k] = (int'(d) < mods[k]) ? int'(d) : mods[k] - 1;
            else if (en)   mq[k] = (mq[k] + 1) % mods[k];
            if (rst)          mo[k] = 1'b0;
            else if (wrap)    mo[k] = 1'b1;
            else if (clr_ovf) mo[k] = 1'b0;
        end
        if (rst) model_valid = 1'b1;
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            chk("q32",   32'(q32),  32'(mq[0]));
            chk("tc32",  32'(tc32), 32'(en && mq[0] == 31));
            chk("ovf32", 32'(ovf32), 32'(mo[0]));
            chk("q10",   32'(q10),  32'(mq[1]));
            chk("tc10",  32'(tc10), 32'(en && mq[1] == 9));
            chk("ovf10", 32'(ovf10), 32'(mo[1]));
        end
    end

    // ---------------- driver ----------------
    // Apply inputs after the falling edge, then return just after the
    // following rising edge so registered outputs can be read.
    task automatic tick(input logic r, input logic e, input logic l,
                        input logic [4:0] dv, input logic c);
        @(negedge clk);
        #1;
        rst = r; en = e; load = l; d = dv; clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tc_hits;
        logic [4:0] e;

        // Reset state
        do_reset();
        tick(0, 0, 0, 0, 0);
        chk("rst_q32", 32'(q32), 0);
        chk("rst_ovf32", 32'(ovf32), 0);
        chk("rst_tc32", 32'(tc32), 0);
        chk("rst_q10", 32'(q10), 0);

        // Modulo 32, 40 counting edges: 1..31, 0..8
        for (int i = 0; i < 40; i++) exp_q.push_back(5'((i + 1) % 32));
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, 0, 0, 0);
            e = exp_q.pop_front();
            chk("count32_q", 32'(q32), 32'(e));
            if (i == 30) chk("count32_ovf_pre", 32'(ovf32), 0);
            if (i == 31) chk("count32_ovf_wrap", 32'(ovf32), 1);
        end

        // Modulo 10, 25 counting edges from reset
        do_reset();
        tc_hits = 0;
        for (int i = 0; i < 25; i++) begin
            tick(0, 1, 0, 0, 0);
            chk("count10_q", 32'(q10), 32'((i + 1) % 10));
            if (tc10) tc_hits++;
            if (i == 8) chk("count10_ovf_pre", 32'(ovf10), 0);
            if (i == 9) chk("count10_ovf_wrap", 32'(ovf10), 1);
        end
        chk("count10_tc_hits", 32'(tc_hits), 2);

        // Load with modulo 10
        do_reset();
        tick(0, 1, 1, 5'd7, 0);
        chk("load7_q10", 32'(q10), 7);
        chk("load7_q32", 32'(q32), 7);
        tick(0, 0, 1, 5'd15, 0);
        chk("load15_q10_sat", 32'(q10), 9);
        chk("load15_q32", 32'(q32), 15);
        tick(0, 1, 0, 0, 0);
        chk("load_wrap_q10", 32'(q10), 0);
        chk("load_wrap_ovf10", 32'(ovf10), 1);
        chk("load_inc_q32", 32'(q32), 16);

        // Priority: load beats wrap, wrap beats clear
        do_reset();
        tick(0, 0, 1, 5'd31, 0);
        chk("prio_q31", 32'(q32), 31);
        chk("prio_tc_en0", 32'(tc32), 0);
        tick(0, 1, 1, 5'd3, 0);
        chk("prio_load_q", 32'(q32), 3);
        chk("prio_load_ovf", 32'(ovf32), 0);
        tick(0, 0, 1, 5'd31, 0);
        tick(0, 1, 0, 0, 0);
        chk("prio_wrap_ovf", 32'(ovf32), 1);
        tick(0, 0, 1, 5'd31, 0);
        tick(0, 1, 0, 0, 1);
        chk("prio_wrapclr_q", 32'(q32), 0);
        chk("prio_wrapclr_ovf", 32'(ovf32), 1);
        tick(0, 0, 0, 0, 1);
        chk("clr_ovf", 32'(ovf32), 0);

        // Reset mid-operation
        tick(0, 0, 1, 5'd31, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 5'd20, 0);
        chk("mid_q20", 32'(q32), 20);
        chk("mid_ovf1", 32'(ovf32), 1);
        tick(1, 1, 1, 5'd5, 0);
        chk("mid_rst_q", 32'(q32), 0);
        chk("mid_rst_ovf", 32'(ovf32), 0);
        chk("mid_rst_tc", 32'(tc32), 0);

        // Hold at 13 with ovf set
        tick(0, 0, 1, 5'd31, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 5'd13, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 0, 0);
            chk("hold_q", 32'(q32), 13);
            chk("hold_tc", 32'(tc32), 0);
            chk("hold_ovf", 32'(ovf32), 1);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_crescente_sinc.md
Name: contador_crescente_sinc

Overview:
- Synchronous up counter, built from JK-style toggle cells. It is the count-up counterpart of the team's 5-bit ripple down counter.
- All flops share one clock, so there is no ripple skew. It supports a programmable modulus, parallel load, count enable, a terminal-count output and a sticky overflow flag.
- It is used as an event counter or as a divide-by-N timebase alongside the down counter.

Parameters:
- WIDTH, 5, counter bit width.
- MODULO, 32, count sequence is 0..MODULO-1. Legal range is 2 to 2**WIDTH; elaboration fails outside this range.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  count enable.
- load  input  1  parallel load strobe.
- d  input  WIDTH  parallel load value.
- clr_ovf  input  1  clears the sticky overflow flag.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count; combinational, equals en AND (q == MODULO-1).
- ovf  output  1  sticky overflow flag (registered).

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. There is no asynchronous path.
- Reset: on a rising edge with rst=1, q <= 0 and ovf <= 0. tc is therefore 0 after reset. rst overrides every other input.
- Priority per edge: rst > load > en. With none of these active, q holds.
- Load (load=1, rst=0):
  - If d < MODULO, q <= d.
  - If d >= MODULO, q <= MODULO-1 (saturate).
  - en is ignored in that cycle. ovf is not set by a load.
- Count (en=1, load=0, rst=0):
  - If q < MODULO-1, q <= q+1.
  - If q == MODULO-1, q <= 0 and ovf <= 1 (wrap).
- Toggle structure:
  - Bit i toggles when en is active and bits 0..i-1 are all 1 (JK with j=k=toggle condition).
  - For a non-power-of-2 MODULO, the wrap overrides toggling with a synchronous clear of all bits.
  - Each cell has hold/set/reset/toggle semantics equivalent to a JK flip-flop, with synchronous reset.
- Latency: q reflects en or load one edge later. tc has zero latency (combinational from q and en).
- tc is high exactly during the cycle in which the next edge causes a wrap, provided load=0 and rst=0. Consumers must qualify tc with load if loads can coincide with it.
- Overflow flag:
  - clr_ovf=1 clears ovf on the next edge.
  - If a wrap and clr_ovf occur on the same edge, set wins: ovf=1.
  - ovf stays 1 until cleared or reset.
- Reset mid-count: any q is forced to 0 on the edge, a pending wrap is discarded, and ovf is cleared.
- Wrap and load on the same edge: load wins and ovf is unchanged.
- For MODULO=2**WIDTH, the wrap is natural binary rollover (all ones to 0) and behaves identically.
- No X propagation: q and ovf are defined from the first rst edge onward.

Test Plan:
- Reset, then en=1 for 40 cycles with defaults (5, 32):
  - q counts 0..31, then 0..7.
  - tc is high only while q=31.
  - ovf goes to 1 on the edge where q goes 31->0.
- MODULO=10: en=1 for 25 cycles:
  - q sequence is 0..9,0..9,0..4.
  - tc is high at q=9 (twice).
  - ovf=1 after the first wrap.
- Load, with MODULO=10:
  - load=1, d=7, en=1 -> q=7 next cycle, no increment.
  - load=1, d=15 -> q=9.
  - Then en=1 for one edge -> q=0 and ovf=1.
- Priority and clear:
  - q=31, en=1, load=1, d=3 on the same edge -> q=3, ovf unchanged (0).
  - q=31, en=1, clr_ovf=1 with ovf=1 -> q=0, ovf stays 1.
  - Then clr_ovf alone -> ovf=0.
- Reset mid-operation: q=20, ovf=1, then rst=1 with en=1 and load=1 for one edge -> q=0, ovf=0, tc=0 after the edge.
- Hold: en=0, load=0 for 10 cycles at q=13 -> q stays 13, tc=0, ovf unchanged.
